// File: rtl/inst_buffer_pkg.sv
// Shared definitions for the fetch/decode instruction buffer: entry layout and
// exception codes carried alongside each fetched instruction.
package inst_buffer_pkg;

  typedef enum logic [3:0] {
    EXC_NONE = 4'd0,
    EXC_INT  = 4'd1,
    EXC_ADEF = 4'd2,
    EXC_ALE  = 4'd3,
    EXC_SYS  = 4'd4,
    EXC_BRK  = 4'd5,
    EXC_INE  = 4'd6,
    EXC_IPE  = 4'd7
  } exception_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        pred_branch_taken;
    logic [31:0] pred_branch_target;
    logic        have_exception;
    exception_t  exception_type;
  } ib_entry_t;

  localparam int IB_ENTRY_W = $bits(ib_entry_t);

endpackage

// File: rtl/inst_buffer.sv
// Circular instruction buffer: up to FETCH_W writes and ISSUE_W in-order head
// reads per cycle, with a variable consume count and flush on redirect.
module inst_buffer
  import inst_buffer_pkg::*;
#(
  parameter  int DEPTH   = 16,
  parameter  int FETCH_W = 2,
  parameter  int ISSUE_W = 2,
  localparam int CNT_W   = $clog2(DEPTH + 1),
  localparam int CONS_W  = $clog2(ISSUE_W + 1),
  localparam int PTR_W   = $clog2(DEPTH)
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          flush,
  input  logic [FETCH_W-1:0]            in_valid,
  input  logic [FETCH_W*IB_ENTRY_W-1:0] in_entry,
  output logic                          in_ready,
  output logic [ISSUE_W-1:0]            out_valid,
  output logic [ISSUE_W*IB_ENTRY_W-1:0] out_entry,
  input  logic [CONS_W-1:0]             consume,
  output logic [CNT_W-1:0]              count
);

  function automatic logic [CNT_W-1:0] popcount(input logic [FETCH_W-1:0] v);
    logic [CNT_W-1:0] n;
    n = '0;
    for (int i = 0; i < FETCH_W; i++) n = n + CNT_W'(v[i]);
    return n;
  endfunction

  // Number of set bits contiguous from slot 0; anything past the first gap is dropped.
  function automatic logic [CNT_W-1:0] lead_ones(input logic [FETCH_W-1:0] v);
    logic [CNT_W-1:0] n;
    logic             run;
    n   = '0;
    run = 1'b1;
    for (int i = 0; i < FETCH_W; i++) begin
      run = run & v[i];
      n   = n + CNT_W'(run);
    end
    return n;
  endfunction

  logic [IB_ENTRY_W-1:0] mem_q [DEPTH];

  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [CNT_W-1:0] avail;
  logic [CNT_W-1:0] push_n;
  logic [CNT_W-1:0] pop_n;

  assign in_ready = ({1'b0, count_q} + (CNT_W+1)'(FETCH_W)) <= (CNT_W+1)'(DEPTH);
  assign count    = count_q;
  assign avail    = (count_q > CNT_W'(ISSUE_W)) ? CNT_W'(ISSUE_W) : count_q;
  assign pop_n    = (CNT_W'(consume) > avail) ? avail : CNT_W'(consume);
  assign push_n   = in_ready ? lead_ones(in_valid) : '0;

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (reset || flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      head_d  = head_q + PTR_W'(pop_n);
      tail_d  = tail_q + PTR_W'(push_n);
      count_d = count_q + push_n - pop_n;
    end
  end

  always_ff @(posedge clk) begin
    head_q  <= head_d;
    tail_q  <= tail_d;
    count_q <= count_d;
  end

  // Storage is not reset; out_valid masking hides stale contents.
  always_ff @(posedge clk) begin
    if (!reset && !flush) begin
      for (int k = 0; k < FETCH_W; k++) begin
        if (CNT_W'(k) < push_n)
          mem_q[tail_q + PTR_W'(k)] <= in_entry[k*IB_ENTRY_W +: IB_ENTRY_W];
      end
    end
  end

  for (genvar gi = 0; gi < ISSUE_W; gi++) begin : g_read
    assign out_valid[gi] = count_q > CNT_W'(gi);
    assign out_entry[gi*IB_ENTRY_W +: IB_ENTRY_W] =
      out_valid[gi] ? mem_q[head_q + PTR_W'(gi)] : '0;
  end

  always_ff @(posedge clk) begin
    if (!reset && !flush) begin
      assert (CNT_W'(consume) <= avail)
        else $warning("inst_buffer: consume %0d exceeds visible entries %0d", consume, avail);
      assert (popcount(in_valid) == lead_ones(in_valid))
        else $warning("inst_buffer: non-contiguous in_valid %b", in_valid);
    end
  end

endmodule

// File: tb/tb_inst_buffer.sv
// Bench for inst_buffer: constant-expectation tables and hand sequences, plus
// random traffic checked against a queue-based model of the buffer.
module tb_inst_buffer;
  import inst_buffer_pkg::*;

  localparam int W = IB_ENTRY_W;
  localparam int DEPTH = 16;

  logic           clk = 1'b0;
  logic           reset, flush;
  logic [1:0]     in_valid;
  logic [2*W-1:0] in_entry;
  logic           in_ready;
  logic [1:0]     out_valid;
  logic [2*W-1:0] out_entry;
  logic [1:0]     consume;
  logic [4:0]     count;

  always #5 clk = ~clk;

  inst_buffer dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_entry(in_entry), .in_ready(in_ready),
    .out_valid(out_valid), .out_entry(out_entry),
    .consume(consume), .count(count)
  );

  ib_entry_t model_q[$];
  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    logic [1:0]  valid;
    logic [31:0] pc0;
    logic [1:0]  cons;
    int          exp_count;
    logic        exp_ready;
    logic [31:0] exp_pc0;
  } vec_t;
  vec_t tbl[16];

  function automatic ib_entry_t mk(input logic [31:0] pc);
    ib_entry_t e;
    e.pc                 = pc;
    e.inst               = pc ^ 32'h1357_2468;
    e.pred_branch_taken  = pc[2];
    e.pred_branch_target = pc + 32'h40;
    e.have_exception     = pc[3];
    e.exception_type     = pc[3] ? EXC_INE : EXC_NONE;
    return e;
  endfunction

  function automatic ib_entry_t rnd_entry();
    ib_entry_t e;
    e.pc                 = $urandom;
    e.inst               = $urandom;
    e.pred_branch_taken  = 1'($urandom_range(0, 1));
    e.pred_branch_target = $urandom;
    e.have_exception     = 1'($urandom_range(0, 1));
    e.exception_type     = exception_t'($urandom_range(0, 7));
    return e;
  endfunction

  function automatic ib_entry_t head(input int i);
    ib_entry_t e;
    e = out_entry[i*W +: W];
    return e;
  endfunction

  task automatic cmp(input string name, input logic [127:0] got, input logic [127:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  task automatic check_model();
    int sz;
    ib_entry_t z;
    z  = '0;
    sz = model_q.size();
    cmp("count", 128'(count), 128'(sz));
    cmp("in_ready", 128'(in_ready), 128'((DEPTH - sz) >= 2));
    cmp("out_valid", 128'(out_valid), 128'({sz > 1, sz > 0}));
    cmp("out_entry0", 128'(head(0)), 128'((sz > 0) ? model_q[0] : z));
    cmp("out_entry1", 128'(head(1)), 128'((sz > 1) ? model_q[1] : z));
  endtask

  task automatic step(input logic [1:0] v, input ib_entry_t e0, input ib_entry_t e1,
                      input logic [1:0] c, input logic f, input logic r);
    int sz, pops;
    logic rdy;
    reset    = r;
    flush    = f;
    in_valid = v;
    consume  = c;
    in_entry = {e1, e0};
    sz  = model_q.size();
    rdy = (DEPTH - sz) >= 2;
    @(posedge clk);
    if (r || f) begin
      model_q.delete();
    end else begin
      pops = int'(c);
      if (pops > sz) pops = sz;
      if (pops > 2) pops = 2;
      repeat (pops) void'(model_q.pop_front());
      if (rdy && v[0]) begin
        model_q.push_back(e0);
        if (v[1]) model_q.push_back(e1);
      end
    end
    #1;
    $display("txn t=%0t valid=%b consume=%0d flush=%b reset=%b -> count=%0d ready=%b out_valid=%b",
             $time, v, c, f, r, count, in_ready, out_valid);
    check_model();
  endtask

  task automatic push2(input logic [31:0] pc);
    step(2'b11, mk(pc), mk(pc + 4), 2'd0, 1'b0, 1'b0);
  endtask

  task automatic idle(input logic [1:0] c, input logic f, input logic r);
    step(2'b00, mk(32'h0), mk(32'h0), c, f, r);
  endtask

  initial begin
    logic [31:0] base;
    reset = 1'b1; flush = 1'b0; in_valid = '0; consume = '0; in_entry = '0;

    // Reset values
    idle(2'd0, 1'b0, 1'b1);
    idle(2'd0, 1'b0, 1'b1);
    cmp("rst_count", 128'(count), 128'(0));
    cmp("rst_ready", 128'(in_ready), 128'(1));
    cmp("rst_out_valid", 128'(out_valid), 128'(0));
    cmp("rst_out_entry", 128'(out_entry), 128'(0));

    // Fill and drain, constant expectations
    for (int i = 0; i < 8; i++) begin
      tbl[i] = '{2'b11, 32'h1c00_0000 + 32'(8 * i), 2'd0, 2 * i + 2, (i < 7), 32'h1c00_0000};
    end
    for (int j = 0; j < 8; j++) begin
      tbl[8 + j] = '{2'b00, 32'h0, 2'd2, 14 - 2 * j, 1'b1,
                     (j < 7) ? 32'h1c00_0000 + 32'(8 * (j + 1)) : 32'h0};
    end
    for (int i = 0; i < 16; i++) begin
      step(tbl[i].valid, mk(tbl[i].pc0), mk(tbl[i].pc0 + 4), tbl[i].cons, 1'b0, 1'b0);
      cmp("tbl_count", 128'(count), 128'(tbl[i].exp_count));
      cmp("tbl_ready", 128'(in_ready), 128'(tbl[i].exp_ready));
      cmp("tbl_head_pc", 128'(head(0).pc), 128'(tbl[i].exp_pc0));
    end

    // Steady push 2 / consume 2 at count 14, streaming across index 15 -> 0
    base = 32'h2000_0000;
    for (int i = 0; i < 7; i++) push2(base + 32'(8 * i));
    cmp("wrap_fill", 128'(count), 128'(14));
    for (int k = 0; k < 20; k++) begin
      step(2'b11, mk(base + 32'(56 + 8 * k)), mk(base + 32'(60 + 8 * k)), 2'd2, 1'b0, 1'b0);
      cmp("wrap_count", 128'(count), 128'(14));
      cmp("wrap_head_pc", 128'(head(0).pc), 128'(base + 32'(8 * (k + 1))));
    end
    // Count 15: in_ready low, so a push alongside consume 2 is dropped
    step(2'b01, mk(32'h2100_0000), mk(32'h0), 2'd0, 1'b0, 1'b0);
    cmp("c15_ready", 128'(in_ready), 128'(0));
    step(2'b11, mk(32'h2100_0004), mk(32'h2100_0008), 2'd2, 1'b0, 1'b0);
    cmp("c15_count", 128'(count), 128'(13));
    idle(2'd0, 1'b1, 1'b0);

    // Partial groups
    step(2'b01, mk(32'h1c00_0000), mk(32'hffff_fff0), 2'd0, 1'b0, 1'b0);
    step(2'b11, mk(32'h1c00_0004), mk(32'h1c00_0008), 2'd0, 1'b0, 1'b0);
    cmp("part_count", 128'(count), 128'(3));
    cmp("part_pc0", 128'(head(0).pc), 128'(32'h1c00_0000));
    cmp("part_pc1", 128'(head(1).pc), 128'(32'h1c00_0004));

    // Flush mid-operation with a push and consume in the same cycle
    push2(32'h1c00_0010);
    step(2'b01, mk(32'h1c00_0018), mk(32'h0), 2'd0, 1'b0, 1'b0);
    cmp("flush_pre", 128'(count), 128'(6));
    step(2'b11, mk(32'h1c00_0020), mk(32'h1c00_0024), 2'd2, 1'b1, 1'b0);
    cmp("flush_count", 128'(count), 128'(0));
    cmp("flush_valid", 128'(out_valid), 128'(0));
    push2(32'h1c00_0040);
    cmp("flush_push_pc", 128'(head(0).pc), 128'(32'h1c00_0040));

    // Reset mid-stream with a push active
    for (int i = 0; i < 4; i++) push2(32'h1c00_0080 + 32'(8 * i));
    cmp("rms_pre", 128'(count), 128'(10));
    step(2'b11, mk(32'h1c00_00f0), mk(32'h1c00_00f4), 2'd1, 1'b0, 1'b1);
    cmp("rms_count", 128'(count), 128'(0));
    cmp("rms_ready", 128'(in_ready), 128'(1));
    cmp("rms_entry", 128'(out_entry), 128'(0));
    step(2'b01, mk(32'h1c00_0100), mk(32'h0), 2'd0, 1'b0, 1'b0);
    cmp("rms_push_pc", 128'(head(0).pc), 128'(32'h1c00_0100));

    // Over-consume is clamped; head advances by exactly one
    idle(2'd2, 1'b0, 1'b0);
    cmp("ovc_count", 128'(count), 128'(0));
    step(2'b01, mk(32'h1c00_0200), mk(32'h0), 2'd0, 1'b0, 1'b0);
    cmp("ovc_head_pc", 128'(head(0).pc), 128'(32'h1c00_0200));

    // Non-contiguous valid writes nothing
    step(2'b10, mk(32'h1c00_0300), mk(32'h1c00_0304), 2'd1, 1'b0, 1'b0);
    cmp("noncontig_count", 128'(count), 128'(0));

    // Random legal traffic
    for (int n = 0; n < 600; n++) begin
      logic [1:0] v, c;
      int sz, cmax;
      sz   = model_q.size();
      cmax = (sz < 2) ? sz : 2;
      case ($urandom_range(0, 2))
        0: v = 2'b00;
        1: v = 2'b01;
        default: v = 2'b11;
      endcase
      c = 2'($urandom_range(0, cmax));
      step(v, rnd_entry(), rnd_entry(), c, ($urandom_range(0, 39) == 0), ($urandom_range(0, 99) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
